// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite read-address capture slice.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_WIDTH = 32;
  localparam int unsigned AXIL_PROT_WIDTH = 3;

  // ARPROT bit positions
  localparam int unsigned ARPROT_PRIV   = 0;
  localparam int unsigned ARPROT_NONSEC = 1;
  localparam int unsigned ARPROT_INSTR  = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } ar_state_t;

endpackage

// File: rtl/axil_ar_stability_checker.sv
// AR channel stability checker: once ARVALID is high without ARREADY, the
// manager must keep ARVALID, ARADDR and ARPROT unchanged until the handshake.
// Any violation sets a sticky error that only reset clears.
module axil_ar_stability_checker
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AXIL_ADDR_WIDTH,
  parameter int unsigned PROT_WIDTH = AXIL_PROT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [PROT_WIDTH-1:0] prot,
  output logic                  err
);

  logic                  wait_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PROT_WIDTH-1:0] prot_q;
  logic                  violation;

  // Violation: previous edge was a wait state and the request moved or vanished
  always_comb begin
    violation = 1'b0;
    if (wait_q && (!valid || (addr != addr_q) || (prot != prot_q))) begin
      violation = 1'b1;
    end
  end

  // Track the previous edge's request and accumulate the sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 1'b0;
      addr_q <= '0;
      prot_q <= '0;
      err    <= 1'b0;
    end else begin
      wait_q <= valid && !ready;
      addr_q <= addr;
      prot_q <= prot;
      if (violation) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_read_address_ms.sv
// AXI4-Lite AR channel capture stage: registers address/protection on each
// ARVALID/ARREADY handshake and holds them until the next one.
// Optional macro AXIL_AR_PROTOCOL_CHECK_EN adds o_proto_err and a stability checker.
// ARESETn is active-high despite its name.
module axil_read_address_ms
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AXIL_ADDR_WIDTH,
  parameter int unsigned PROT_WIDTH = AXIL_PROT_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] i_ARADDR,
  output logic [ADDR_WIDTH-1:0] o_ARADDR,
  input  logic [PROT_WIDTH-1:0] ARPROT,
  output logic [PROT_WIDTH-1:0] o_ARPROT,
  output logic                  o_ar_accepted,
  output logic                  o_misaligned
`ifdef AXIL_AR_PROTOCOL_CHECK_EN
  ,
  output logic                  o_proto_err
`endif
);

  ar_state_t state;
  ar_state_t state_next;
  logic      handshake;

  assign handshake = ARVALID && ARREADY;

  // Next-state logic: stay CAPTURED while handshakes keep arriving
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = handshake ? CAPTURED : IDLE;
      CAPTURED: state_next = handshake ? CAPTURED : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register and capture of address/attributes on handshake
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state        <= IDLE;
      o_ARADDR     <= '0;
      o_ARPROT     <= '0;
      o_misaligned <= 1'b0;
    end else begin
      state <= state_next;
      if (handshake) begin
        o_ARADDR     <= i_ARADDR;
        o_ARPROT     <= ARPROT;
        o_misaligned <= (i_ARADDR[1:0] != 2'b00);
      end
    end
  end

  assign o_ar_accepted = (state == CAPTURED);

`ifdef AXIL_AR_PROTOCOL_CHECK_EN
  axil_ar_stability_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PROT_WIDTH (PROT_WIDTH)
  ) u_checker (
    .clk   (ACLK),
    .rst   (ARESETn),
    .valid (ARVALID),
    .ready (ARREADY),
    .addr  (i_ARADDR),
    .prot  (ARPROT),
    .err   (o_proto_err)
  );
`endif

endmodule

// File: tb/tb_axil_read_address_ms.sv
// Directed scoreboard bench for axil_read_address_ms.
// Covers AXIL_AR_PROTOCOL_CHECK_EN when that macro is defined.
module tb_axil_read_address_ms;

  logic        ACLK;
  logic        ARESETn;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] i_ARADDR;
  logic [31:0] o_ARADDR;
  logic [2:0]  ARPROT;
  logic [2:0]  o_ARPROT;
  logic        o_ar_accepted;
  logic        o_misaligned;
`ifdef AXIL_AR_PROTOCOL_CHECK_EN
  logic        o_proto_err;
`endif

  axil_read_address_ms #(
    .ADDR_WIDTH (32),
    .PROT_WIDTH (3)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .ARVALID       (ARVALID),
    .ARREADY       (ARREADY),
    .i_ARADDR      (i_ARADDR),
    .o_ARADDR      (o_ARADDR),
    .ARPROT        (ARPROT),
    .o_ARPROT      (o_ARPROT),
    .o_ar_accepted (o_ar_accepted),
    .o_misaligned  (o_misaligned)
`ifdef AXIL_AR_PROTOCOL_CHECK_EN
    ,
    .o_proto_err   (o_proto_err)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic        acc;
    logic        mis;
    logic        perr;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state (values after the most recent edge)
  logic [31:0] m_addr  = '0;
  logic [2:0]  m_prot  = '0;
  logic        m_acc   = 1'b0;
  logic        m_mis   = 1'b0;
  logic        m_perr  = 1'b0;
  logic        m_wait  = 1'b0;
  logic [31:0] m_paddr = '0;
  logic [2:0]  m_pprot = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict, push, then pop and compare after the edge
  task automatic step(input string tag, input logic rst, input logic v, input logic r,
                      input logic [31:0] a, input logic [2:0] p);
    exp_t e;
    @(negedge ACLK);
    ARESETn  = rst;
    ARVALID  = v;
    ARREADY  = r;
    i_ARADDR = a;
    ARPROT   = p;
    if (rst) begin
      m_addr = '0; m_prot = '0; m_acc = 1'b0; m_mis = 1'b0;
      m_perr = 1'b0; m_wait = 1'b0; m_paddr = '0; m_pprot = '0;
    end else begin
      if (m_wait && (!v || a != m_paddr || p != m_pprot)) m_perr = 1'b1;
      m_wait  = v && !r;
      m_paddr = a;
      m_pprot = p;
      if (v && r) begin
        m_addr = a;
        m_prot = p;
        m_mis  = (a % 4) != 0;
        m_acc  = 1'b1;
      end else begin
        m_acc = 1'b0;
      end
    end
    e.tag = tag; e.addr = m_addr; e.prot = m_prot;
    e.acc = m_acc; e.mis = m_mis; e.perr = m_perr;
    q.push_back(e);
    @(posedge ACLK);
    #1;
    tests++;
    assert (q.size() == 1) else begin
      fails++;
      $error("FAIL %s_queue observed=%0d expected=1", tag, q.size());
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, "_addr"}, o_ARADDR, e.addr);
      chk({e.tag, "_prot"}, {29'd0, o_ARPROT}, {29'd0, e.prot});
      chk({e.tag, "_acc"}, {31'd0, o_ar_accepted}, {31'd0, e.acc});
      chk({e.tag, "_mis"}, {31'd0, o_misaligned}, {31'd0, e.mis});
`ifdef AXIL_AR_PROTOCOL_CHECK_EN
      chk({e.tag, "_perr"}, {31'd0, o_proto_err}, {31'd0, e.perr});
`endif
    end
  endtask

  initial begin
    ARESETn = 1'b1; ARVALID = 1'b1; ARREADY = 1'b1;
    i_ARADDR = 32'hFFFFFFFF; ARPROT = 3'b111;

    // Reset beats a simultaneous handshake
    step("rst0", 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 3'b111);
    step("rst1", 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 3'b111);
    // Wait states: no capture
    step("wait0", 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b000);
    step("wait1", 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b000);
    // Handshake on misaligned all-ones address
    step("hs_ff", 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 3'b000);
    // Ready without valid: hold
    step("rdy_only", 1'b0, 1'b0, 1'b1, 32'h00001000, 3'b000);
    // Back-to-back aligned handshakes
    step("b2b_10", 1'b0, 1'b1, 1'b1, 32'h00000010, 3'b010);
    step("b2b_14", 1'b0, 1'b1, 1'b1, 32'h00000014, 3'b010);
    step("idle0", 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000);
    // Misaligned by 2 with distinct attributes
    step("hs_mis2", 1'b0, 1'b1, 1'b1, 32'hA5A5A5A2, 3'b101);
    step("hs_mis1", 1'b0, 1'b1, 1'b1, 32'h00000001, 3'b001);
    step("idle1", 1'b0, 1'b0, 1'b1, 32'h12345678, 3'b110);
    // Reset in the same edge as a handshake discards it
    step("rst_mid", 1'b1, 1'b1, 1'b1, 32'h0BADF00C, 3'b111);
    step("post_rst", 1'b0, 1'b0, 1'b0, 32'h0BADF00C, 3'b111);
    // Wait state with address change (protocol error when checker is present)
    step("chg_20", 1'b0, 1'b1, 1'b0, 32'h00000020, 3'b000);
    step("chg_24", 1'b0, 1'b1, 1'b0, 32'h00000024, 3'b000);
    step("chg_hs", 1'b0, 1'b1, 1'b1, 32'h00000024, 3'b000);
    step("sticky0", 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000);
    step("sticky1", 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000);
    step("rst_clr", 1'b1, 1'b0, 1'b0, 32'h00000000, 3'b000);
    // Legal wait then handshake: no error; then valid dropped during a wait
    step("ok_wait", 1'b0, 1'b1, 1'b0, 32'h00000030, 3'b100);
    step("ok_hs", 1'b0, 1'b1, 1'b1, 32'h00000030, 3'b100);
    step("drop_w", 1'b0, 1'b1, 1'b0, 32'h00000040, 3'b000);
    step("drop_v", 1'b0, 1'b0, 1'b0, 32'h00000040, 3'b000);
    step("prot_w", 1'b0, 1'b0, 1'b0, 32'h00000040, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
